// File: rtl/dcp_tx_arb.sv
// ---------------------------------------------------------------------------
// dcp_tx_arb
//
// Round-robin arbiter that shares one transmitter between four requesters.
// A requester raises req_in[i] with its payload on dout_in[32i+31:32i] and
// its type bit on type_in[i], and holds the request until ack_out[i].
// The winner's payload and type are captured when it is granted, so the
// transmitter sees stable data no matter what the requesters do afterwards.
//
// Flow: IDLE -> GRANT (req_tx high, wait for ack_tx) -> RELEASE (wait for the
// granted requester to drop its request) -> IDLE. A requester that drops its
// request while still in GRANT aborts the transfer and goes straight back to
// IDLE without an acknowledge. After every grant the search pointer moves to
// the requester just after the one served.
//
// Optional feature: define DCP_TX_ARB_TIMEOUT_EN to add a GRANT watchdog.
// After TIMEOUT_CYC cycles in GRANT without ack_tx the grant is released
// with a one-cycle ack_out/timeout_err pulse. Without the macro the arbiter
// waits in GRANT indefinitely and timeout_err is held low.
//
// Parameters
//   TIMEOUT_CYC  GRANT-cycle limit before a forced release (2..65535)
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rstn         synchronous active-low reset
//   req_in[3:0]  per-requester transmit request
//   dout_in      per-requester 32-bit payload, slot i at [32i+31:32i]
//   type_in[3:0] per-requester type bit
//   ack_out[3:0] per-requester acknowledge, one-hot or zero
//   req_tx       request to the shared transmitter
//   dout_tx      captured payload to the transmitter
//   type_tx      captured type to the transmitter
//   ack_tx       transmitter completion acknowledge
//   grant_id     index of the current or most recent grant
//   busy         high whenever the arbiter is not idle
//   timeout_err  one-cycle pulse on a watchdog release
// ---------------------------------------------------------------------------
module dcp_tx_arb #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [3:0]   req_in,
  input  logic [127:0] dout_in,
  input  logic [3:0]   type_in,
  output logic [3:0]   ack_out,
  output logic         req_tx,
  output logic [31:0]  dout_tx,
  output logic         type_tx,
  input  logic         ack_tx,
  output logic [1:0]   grant_id,
  output logic         busy,
  output logic         timeout_err
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout_cyc
    $error("dcp_tx_arb: TIMEOUT_CYC must lie in 2..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_ptr;
  logic [1:0]  w_ptr_nxt;
  logic [1:0]  r_grant_id;
  logic [1:0]  w_grant_id_nxt;
  logic        r_req_tx;
  logic        w_req_tx_nxt;
  logic [31:0] r_dout_tx;
  logic [31:0] w_dout_tx_nxt;
  logic        r_type_tx;
  logic        w_type_tx_nxt;

  logic [1:0]  w_sel;
  logic [31:0] w_dout_sel;
  logic        w_req_cur;
  logic        w_timeout;

  // First requester at or above the pointer, wrapping modulo 4. Walking
  // the offsets downward lets the smallest offset win the last assignment.
  function automatic logic [1:0] pick_next(input logic [3:0] req,
                                           input logic [1:0] ptr);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + k[1:0];
      if (req[idx]) begin
        pick = idx;
      end
    end
    return pick;
  endfunction

  assign w_sel      = pick_next(req_in, r_ptr);
  assign w_dout_sel = dout_in[{w_sel, 5'd0} +: 32];
  assign w_req_cur  = req_in[r_grant_id];

`ifdef DCP_TX_ARB_TIMEOUT_EN
  localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;

  // The watchdog fires only if the transmitter has not acknowledged and the
  // requester is still waiting; an ack or an abort in the same cycle wins.
  assign w_timeout = (r_state == S_GRANT) && !ack_tx && w_req_cur &&
                     (r_cnt == LP_CNT_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_grant_id_nxt = r_grant_id;
    w_req_tx_nxt   = r_req_tx;
    w_dout_tx_nxt  = r_dout_tx;
    w_type_tx_nxt  = r_type_tx;
`ifdef DCP_TX_ARB_TIMEOUT_EN
    // Counter is zero everywhere outside GRANT, so it restarts per grant.
    w_cnt_nxt      = 16'd0;
`endif
    case (r_state)
      S_IDLE: begin
        if (|req_in) begin
          w_grant_id_nxt = w_sel;
          w_dout_tx_nxt  = w_dout_sel;
          w_type_tx_nxt  = type_in[w_sel];
          w_req_tx_nxt   = 1'b1;
          w_state_nxt    = S_GRANT;
        end
      end
      S_GRANT: begin
        if (ack_tx) begin
          // Ack takes precedence over a simultaneous request drop.
          w_req_tx_nxt = 1'b0;
          w_state_nxt  = S_RELEASE;
        end else if (!w_req_cur) begin
          w_req_tx_nxt = 1'b0;
          w_state_nxt  = S_IDLE;
          w_ptr_nxt    = r_grant_id + 2'd1;
        end
`ifdef DCP_TX_ARB_TIMEOUT_EN
        else if (w_timeout) begin
          w_req_tx_nxt = 1'b0;
          w_state_nxt  = S_RELEASE;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
`endif
      end
      S_RELEASE: begin
        if (!w_req_cur) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = r_grant_id + 2'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_ptr      <= 2'd0;
      r_grant_id <= 2'd0;
      r_req_tx   <= 1'b0;
      r_dout_tx  <= 32'd0;
      r_type_tx  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_req_tx   <= w_req_tx_nxt;
      r_dout_tx  <= w_dout_tx_nxt;
      r_type_tx  <= w_type_tx_nxt;
    end
  end

`ifdef DCP_TX_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`endif

  // Acknowledge is combinational so the requester sees it in the same
  // cycle as ack_tx (or the watchdog expiry).
  always_comb begin
    ack_out = 4'd0;
    if ((r_state == S_GRANT) && (ack_tx || w_timeout)) begin
      ack_out[r_grant_id] = 1'b1;
    end
  end

  assign req_tx      = r_req_tx;
  assign dout_tx     = r_dout_tx;
  assign type_tx     = r_type_tx;
  assign grant_id    = r_grant_id;
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = w_timeout;

endmodule
